// File: rtl/uart_rx8_if.sv
// Serial receive bundle: the line in, plus received byte and status pulses out.
// The slave side belongs to the receiver; the master side drives the line.
interface uart_rx8_if;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (output rxd, input data, input valid, input frame_err, input busy);
    modport slave  (input rxd, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx8.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling, one-cycle valid/frame_err
// pulses, and a BREAK state that blocks restart while the line is held low.
module uart_rx8 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx8_if.slave  bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          ok_pend_q, ok_pend_d;
    logic          err_pend_q, err_pend_d;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          busy_q;
    logic          sync1_q;
    logic          rxd_s;

    // Two-flop synchronizer on the asynchronous line; reset to the idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rxd_s   <= 1'b1;
        end else begin
            sync1_q <= bus.rxd;
            rxd_s   <= sync1_q;
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            ok_pend_q  <= 1'b0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            ok_pend_q  <= ok_pend_d;
            err_pend_q <= err_pend_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    // Next-state logic: bit timing, sampling and frame outcome.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        ok_pend_d  = 1'b0;
        err_pend_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        ok_pend_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        err_pend_d = 1'b1;
                        state_d    = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BREAK: begin
                // Only a return to the idle level may rearm start detection.
                if (rxd_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Output stage: the frame result lands one cycle after the stop-bit sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= ok_pend_q;
            frame_err_q <= err_pend_q;
            if (ok_pend_q) begin
                data_q <= shift_q;
            end else begin
                data_q <= data_q;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx8.sv
// Bench for uart_rx8: builds a per-cycle line/reset waveform plus the expected
// outputs derived from frame timing arithmetic, then replays it and compares every cycle.
module tb_uart_rx8;

    localparam int C    = 16;
    localparam int H    = C / 2;
    // Line driven low at index s: two synchronizer edges, START entry, then H + 9C + 1.
    localparam int LAT  = 2 + H + 9 * C + 1;
    localparam int MAXC = 4000;

    logic clk;
    logic rst;

    uart_rx8_if bus ();

    uart_rx8 #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit         rxd_w [MAXC];
    bit         rst_w [MAXC];
    bit         v_exp [MAXC];
    bit         e_exp [MAXC];
    bit         b_exp [MAXC];
    logic [7:0] d_at  [MAXC];
    int         n;
    int         total;
    int         bad;

    task automatic put(input bit r, input bit rs);
        rxd_w[n] = r;
        rst_w[n] = rs;
        n++;
    endtask

    task automatic busy_win(input int a, input int b);
        for (int i = a; i < b; i++) begin
            if (i < MAXC) b_exp[i] = 1'b1;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) put(1'b1, 1'b1);
    endtask

    task automatic frame(input logic [7:0] b, input bit stop_ok, input int extra_low, input bit noisy);
        int s;
        logic [9:0] bits;
        s = n;
        bits = {stop_ok, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < C; j++) begin
                bit v;
                v = bits[k];
                if (noisy && k >= 1 && k <= 8 && (j == 1 || j == 2)) v = ~v;
                put(v, 1'b1);
            end
        end
        if (stop_ok) begin
            v_exp[s + LAT] = 1'b1;
            d_at[s + LAT]  = b;
            busy_win(s + 2, s + LAT - 1);
        end else begin
            repeat (extra_low) put(1'b0, 1'b1);
            e_exp[s + LAT] = 1'b1;
            busy_win(s + 2, n + 2);
        end
    endtask

    task automatic glitch(input int w);
        int g;
        g = n;
        repeat (w) put(1'b0, 1'b1);
        busy_win(g + 2, g + 2 + H);
    endtask

    task automatic reset_frame(input logic [7:0] b);
        int s;
        logic [9:0] bits;
        s = n;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < C; j++) begin
                put(bits[k], !((k * C + j) >= (5 * C + H)));
            end
        end
        busy_win(s + 2, s + 5 * C + H);
    endtask

    initial begin
        logic [7:0] data_m;
        logic [7:0] rb;
        n = 0;
        total = 0;
        bad = 0;
        rst = 1'b0;
        bus.rxd = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            v_exp[i] = 1'b0;
            e_exp[i] = 1'b0;
            b_exp[i] = 1'b0;
            d_at[i]  = 8'h00;
        end

        repeat (5) put(1'b1, 1'b0);
        idle(100);
        frame(8'hA5, 1'b1, 0, 1'b0);
        idle(20);
        frame(8'h3C, 1'b1, 0, 1'b0);
        frame(8'hFF, 1'b1, 0, 1'b0);
        idle(20);
        glitch(4);
        idle(40);
        frame(8'h55, 1'b0, 50, 1'b0);
        idle(20);
        frame(8'h12, 1'b1, 0, 1'b0);
        idle(20);
        reset_frame(8'hC3);
        idle(20);
        frame(8'h81, 1'b1, 0, 1'b0);
        idle(20);
        for (int r = 0; r < 4; r++) begin
            rb = 8'($urandom_range(0, 255));
            frame(rb, 1'b1, 0, (r == 1));
            idle(int'($urandom_range(0, 20)));
        end
        idle(30);

        data_m = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rxd = rxd_w[i];
            rst = rst_w[i];
            @(posedge clk);
            #1;
            if (!rst_w[i]) data_m = 8'h00;
            else if (v_exp[i]) data_m = d_at[i];

            total++;
            assert (bus.valid === v_exp[i]) else begin
                bad++;
                $error("FAIL valid cyc=%0d got=%b exp=%b", i, bus.valid, v_exp[i]);
            end
            total++;
            assert (bus.frame_err === e_exp[i]) else begin
                bad++;
                $error("FAIL frame_err cyc=%0d got=%b exp=%b", i, bus.frame_err, e_exp[i]);
            end
            total++;
            assert (bus.data === data_m) else begin
                bad++;
                $error("FAIL data cyc=%0d got=%h exp=%h", i, bus.data, data_m);
            end
            total++;
            assert (bus.busy === b_exp[i]) else begin
                bad++;
                $error("FAIL busy cyc=%0d got=%b exp=%b", i, bus.busy, b_exp[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx8.md
UART_RX8 -- requirements
Module: uart_rx8

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; even integer, minimum 4.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset; rst is asynchronous, active-low, and the clock is clk.
REQ-004 rxd  input  1  asynchronous serial line: idle high, 8N1, LSB first.
REQ-005 data  output  8  last correctly framed byte, held stable until the next good frame; drives the downstream 8-bit register d input.
REQ-006 valid  output  1  single-cycle pulse: data updated this cycle.
REQ-007 frame_err  output  1  single-cycle pulse: stop bit sampled low.
REQ-008 busy  output  1  high whenever state is not IDLE.

Function
REQ-009 rxd SHALL pass through a two-flop synchronizer; all logic SHALL use only the second flop output (rxd_s).
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP and BREAK, with one cycle counter cnt of width ceil(log2(CLKS_PER_BIT)) and a 3-bit bit index.
REQ-011 IDLE: on an edge where rxd_s==0, go to START with cnt=0; otherwise stay.
REQ-012 START: increment cnt; at cnt==CLKS_PER_BIT/2-1 (mid start bit), go to DATA with cnt=0 and index=0 if rxd_s==0, else return to IDLE (glitch reject, no output activity).
REQ-013 DATA: increment cnt; at cnt==CLKS_PER_BIT-1, shift rxd_s into the shift register MSB (right shift, so the first bit ends in bit 0), clear cnt, increment index; after the 8th sample (index==7) go to STOP.
REQ-014 STOP: at cnt==CLKS_PER_BIT-1, if rxd_s==1, load data from the shift register, assert valid on the next cycle, and go to IDLE.
REQ-015 STOP: at cnt==CLKS_PER_BIT-1, if rxd_s==0, assert frame_err on the next cycle, leave data unchanged, and go to BREAK.
REQ-016 BREAK: stay until rxd_s==1, then go to IDLE; no new frame SHALL start while the line is held low.
REQ-017 Latency: valid SHALL rise exactly CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the START-entry edge (153 cycles for CLKS_PER_BIT=16).
REQ-018 valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-019 Back-to-back frames SHALL be accepted: a start bit arriving at any point after the STOP sample is detected from IDLE with no lost frame.
REQ-020 rxd activity during DATA or STOP other than at sample points SHALL have no effect.

Reset
REQ-021 While rst==0: state=IDLE, cnt=0, index=0, shift register=8'h00, data=8'h00, valid=0, frame_err=0, busy=0, both synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL discard the partial byte; after release, the next reception SHALL require a fresh falling edge seen from IDLE.

Verification
REQ-023 Reset then idle line for 100 cycles -> data=8'h00, valid=0, frame_err=0, busy=0 throughout.
REQ-024 CLKS_PER_BIT=16, send 8'hA5 framed 8N1 -> one valid pulse 153 cycles after START entry, data=8'hA5, frame_err=0.
REQ-025 Send 8'h3C then 8'hFF back-to-back with zero idle bits -> two valid pulses, data=8'h3C then 8'hFF.
REQ-026 Low glitch of 4 cycles on idle rxd -> FSM returns to IDLE at the mid-start sample, no valid, no frame_err, data unchanged.
REQ-027 Send 8'h55 with the stop bit low, then hold low 50 cycles, then high -> one frame_err pulse, data keeps its previous value, busy stays high until the line returns high; a following 8'h12 is received correctly.
REQ-028 Assert rst during bit 4 of 8'hC3, release, then send 8'h81 -> data=8'h00 during reset, then a single valid with data=8'h81.
